tilemap_scanner: RTL and testbench
==================================

Name: tilemap_scanner

Overview:
- Upstream sequencer for tile_drawer. On a start pulse it walks a MAP_W x MAP_H tile map in row-major order.
- For each cell it reads one tile index from the map ROM/RAM and converts it to a tile_drawer ROM base address plus screen x/y.
- It pulses draw, then waits for the drawer's done before moving on. It signals frame_done once the whole map has been issued.

Parameters:
- MAP_W, 20, tiles per map row (160 px / 8).
- MAP_H, 15, tile rows per map (120 px / 8).
- MAP_AW, 9, map address width; must satisfy 2^MAP_AW >= MAP_W*MAP_H.
- TILE_BASE, 16'h0000, tile ROM address of tile index 0.
- TILE_SHIFT, 6, log2 of words per tile (8x8 = 64).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame scan when idle
- map_address  out  MAP_AW  map memory read address
- map_data  in  8  tile index; valid 1 cycle after map_address
- tile_address  out  16  tile ROM base address for the drawer
- x_out  out  8  screen x of tile's top-left pixel
- y_out  out  8  screen y of tile's top-left pixel
- draw  out  1  one-cycle request to tile_drawer
- drawer_done  in  1  tile_drawer done pulse
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last tile completes

Behaviour:
- All outputs and state are registered. The following are set when reset is sampled high at posedge clk (synchronous): state=S_IDLE, col=0, row=0, map_address=0, tile_address=0, x_out=0, y_out=0, draw=0, busy=0, frame_done=0.
- Reset mid-scan aborts immediately. A drawer already running finishes on its own, and its done is ignored.
- States:
  - S_IDLE: busy=0. start -> S_FETCH with col=row=0. start is ignored in every other state.
  - S_FETCH: map_address <= row*MAP_W + col (running index counter; no multiplier needed) -> S_WAIT_MAP.
  - S_WAIT_MAP: 1-cycle memory latency -> S_ISSUE.
  - S_ISSUE: latch tile_address <= TILE_BASE + (map_data << TILE_SHIFT), computed 16-bit with wrap. Latch x_out <= col<<3, y_out <= row<<3. Assert draw for exactly this one cycle -> S_WAIT_DONE.
  - S_WAIT_DONE: hold tile_address/x_out/y_out stable. drawer_done -> S_ADVANCE.
  - S_ADVANCE:
    - if col==MAP_W-1 and row==MAP_H-1 -> S_FINISH;
    - else if col==MAP_W-1 then col<=0, row<=row+1 -> S_FETCH;
    - else col<=col+1 -> S_FETCH.
  - S_FINISH: frame_done=1 for one cycle, busy<=0 -> S_IDLE.
- Handshake rules:
  - draw never reasserts before drawer_done has been seen for the previous tile.
  - drawer_done is ignored outside S_WAIT_DONE.
  - drawer_done arriving in the same cycle as draw is impossible for a compliant drawer and is ignored.
- Per-tile latency:
  - tile issue = 4 cycles of overhead (FETCH, WAIT_MAP, ISSUE, ADVANCE) plus the drawer time;
  - start to first draw = 3 cycles.
- Width rules: x_out/y_out are truncated to 8 bits. Maps wider than 32 tiles wrap x, and no error is flagged.

Optional Feature:
- Macro: TILEMAP_SKIP_EMPTY_EN.
- Defined: in S_ISSUE, a map_data of 8'h00 suppresses draw and goes straight to S_ADVANCE. Empty tiles then cost 4 cycles and are left as the background.
- Undefined: index 0 is drawn like any other tile.

Decomposition:
- Shared package (tile_pkg): TILE_PX=8, TILE_SHIFT, SCREEN_W=160, SCREEN_H=120, MAP_W, MAP_H, and the state encoding localparams.
- One natural sub-module: tile_index_counter, holding col/row/linear index with wrap and last-cell flag. The FSM stays in tilemap_scanner.

Test Plan:
- Reset then a single start, with a 2x2 map (MAP_W=2, MAP_H=2) containing {3,0,1,2} and a drawer model giving done 5 cycles after draw:
  - expect draws at (0,0) addr 0x00C0, (8,0) 0x0000, (0,8) 0x0040, (8,8) 0x0080;
  - expect one frame_done, then busy=0.
- Timing check: start at cycle T gives the first draw at T+3. The next map_address changes exactly 2 cycles after drawer_done.
- start pulses during the scan and a spurious drawer_done in S_FETCH -> no extra draws, no skipped tiles, and the tile count still equals 4.
- Reset asserted during S_WAIT_DONE of tile 2 -> next cycle busy=0, draw=0, all outputs 0. A new start rescans from tile 0.
- Full 20x15 map with indices = cell mod 256 ->
  - 300 draws;
  - last draw at x=152, y=112;
  - tile_address for index 255 = 0x3FC0.
- With TILEMAP_SKIP_EMPTY_EN defined, the 2x2 map above -> 3 draws only, and the (8,0) cell is skipped. Without the macro -> 4 draws.

Source files
------------

// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_pkg
// Description : Shared constants for the tile map scanner. Holds the tile
//               geometry, the screen/map dimensions and the scanner FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tile_pkg;

    localparam int TILE_PX       = 8;                  // tile edge in pixels
    localparam int TILE_PX_SHIFT = $clog2(TILE_PX);    // cell -> pixel shift
    localparam int TILE_SHIFT    = 6;                  // log2(words per tile)
    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int MAP_W         = SCREEN_W / TILE_PX; // 20 tiles per row
    localparam int MAP_H         = SCREEN_H / TILE_PX; // 15 tile rows

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH     = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT_MAP  = 3'd2;
    localparam logic [STATE_W-1:0] S_ISSUE     = 3'd3;
    localparam logic [STATE_W-1:0] S_WAIT_DONE = 3'd4;
    localparam logic [STATE_W-1:0] S_ADVANCE   = 3'd5;
    localparam logic [STATE_W-1:0] S_FINISH    = 3'd6;

endpackage
`default_nettype wire

// File: rtl/tile_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : tile_index_counter
// Description : Row-major cell walker for the tile map. Keeps column, row and
//               the linear map index in step so no multiplier is needed.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               clear       - restart from cell 0
//               advance     - step to the next cell
//               col, row    - current cell coordinates
//               index       - row*MAP_W + col
//               last        - current cell is the final cell of the map
// Revision    : 1.0 - initial release
// ============================================================================
module tile_index_counter #(
    parameter int MAP_W  = 20,
    parameter int MAP_H  = 15,
    parameter int MAP_AW = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [7:0]        col,
    output logic [7:0]        row,
    output logic [MAP_AW-1:0] index,
    output logic              last
);
    import tile_pkg::*;

    localparam logic [7:0] c_COL_MAX = 8'(MAP_W - 1);
    localparam logic [7:0] c_ROW_MAX = 8'(MAP_H - 1);

    logic [7:0]        r_col;
    logic [7:0]        r_row;
    logic [MAP_AW-1:0] r_index;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_col   <= '0;
            r_row   <= '0;
            r_index <= '0;
        end else if (advance) begin
            r_index <= r_index + 1'b1;
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col   = r_col;
    assign row   = r_row;
    assign index = r_index;
    assign last  = (r_col == c_COL_MAX) && (r_row == c_ROW_MAX);

endmodule
`default_nettype wire

// File: rtl/tilemap_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tilemap_scanner
// Description : Walks a MAP_W x MAP_H tile map in row-major order, reads one
//               tile index per cell and issues a draw request (ROM base
//               address plus screen x/y) to tile_drawer, waiting for its done
//               before moving on. Pulses frame_done after the last tile.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               start                - begin a frame scan when idle
//               map_address/map_data - map memory read (1-cycle latency)
//               tile_address, x_out, y_out, draw - request to tile_drawer
//               drawer_done          - drawer completion pulse
//               busy, frame_done     - scan status
// Options     : TILEMAP_SKIP_EMPTY_EN - when defined, cells holding index 0
//               are not drawn and are left as background.
// Revision    : 1.0 - initial release
// ============================================================================
module tilemap_scanner #(
    parameter int          MAP_W      = tile_pkg::MAP_W,
    parameter int          MAP_H      = tile_pkg::MAP_H,
    parameter int          MAP_AW     = 9,
    parameter logic [15:0] TILE_BASE  = 16'h0000,
    parameter int          TILE_SHIFT = tile_pkg::TILE_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [MAP_AW-1:0] map_address,
    input  logic [7:0]        map_data,
    output logic [15:0]       tile_address,
    output logic [7:0]        x_out,
    output logic [7:0]        y_out,
    output logic              draw,
    input  logic              drawer_done,
    output logic              busy,
    output logic              frame_done
);
    import tile_pkg::*;

    logic [STATE_W-1:0] r_state;

    logic [7:0]        w_col;
    logic [7:0]        w_row;
    logic [MAP_AW-1:0] w_index;
    logic              w_last;
    logic              w_clear;
    logic              w_advance;
    logic              w_skip;
    logic [15:0]       w_tile_offset;
    logic [15:0]       w_tile_address;

    assign w_clear   = (r_state == S_IDLE) && start;
    assign w_advance = (r_state == S_ADVANCE) && !w_last;

    tile_index_counter #(
        .MAP_W  (MAP_W),
        .MAP_H  (MAP_H),
        .MAP_AW (MAP_AW)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .advance (w_advance),
        .col     (w_col),
        .row     (w_row),
        .index   (w_index),
        .last    (w_last)
    );

    // 16-bit arithmetic; large indices simply wrap.
    assign w_tile_offset  = {8'd0, map_data} << TILE_SHIFT;
    assign w_tile_address = TILE_BASE + w_tile_offset;

`ifdef TILEMAP_SKIP_EMPTY_EN
    assign w_skip = (map_data == 8'h00);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            map_address  <= '0;
            tile_address <= '0;
            x_out        <= '0;
            y_out        <= '0;
            draw         <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            draw       <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    map_address <= w_index;
                    r_state     <= S_WAIT_MAP;
                end
                S_WAIT_MAP: begin
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_skip) begin
                        r_state <= S_ADVANCE;
                    end else begin
                        tile_address <= w_tile_address;
                        x_out        <= w_col << TILE_PX_SHIFT;
                        y_out        <= w_row << TILE_PX_SHIFT;
                        draw         <= 1'b1;
                        r_state      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // A done coincident with our own draw cycle cannot belong
                    // to this tile, so it is discarded.
                    if (drawer_done && !draw) begin
                        r_state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    r_state <= w_last ? S_FINISH : S_FETCH;
                end
                S_FINISH: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tilemap_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_tilemap_scanner
// Description : Directed self-checking bench for tilemap_scanner. Instance A
//               scans a 2x2 map {3,0,1,2}, instance B the full 20x15 map
//               holding cell mod 256. Each instance has a map memory with one
//               cycle of read latency and a drawer model answering draw with
//               a single-cycle done after a fixed delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tilemap_scanner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A : 2x2 map ----------------
    logic        a_start = 1'b0;
    logic [1:0]  a_map_address;
    logic [7:0]  a_map_data = 8'd0;
    logic [15:0] a_tile_address;
    logic [7:0]  a_x, a_y;
    logic        a_draw, a_done = 1'b0, a_busy, a_fd;

    tilemap_scanner #(.MAP_W(2), .MAP_H(2), .MAP_AW(2),
                      .TILE_BASE(16'h0000), .TILE_SHIFT(6)) dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .map_address(a_map_address), .map_data(a_map_data),
        .tile_address(a_tile_address), .x_out(a_x), .y_out(a_y),
        .draw(a_draw), .drawer_done(a_done), .busy(a_busy), .frame_done(a_fd)
    );

    logic [7:0] a_mem [4];
    logic [1:0] a_rd_addr = 2'd0, a_prev_addr = 2'd0;
    int a_lx[$], a_ly[$], a_la[$], a_lc[$], a_dcyc[$];
    int a_acyc[4];
    int a_fd_cnt = 0, a_cnt = 0, a_spur_cnt = 0;
    bit a_spur_en = 1'b0;
    int ea_x[$], ea_y[$], ea_a[$];

    always @(negedge clk) begin
        if (a_draw) begin
            a_lx.push_back(int'(a_x));
            a_ly.push_back(int'(a_y));
            a_la.push_back(int'(a_tile_address));
            a_lc.push_back(cyc);
        end
        if (a_fd) a_fd_cnt++;
        if (a_map_address != a_prev_addr) a_acyc[a_map_address] = cyc;
        a_prev_addr = a_map_address;
        a_map_data  = a_mem[a_rd_addr];
        a_rd_addr   = a_map_address;
        a_done = 1'b0;
        if (a_spur_cnt > 0) begin
            a_spur_cnt--;
            if (a_spur_cnt == 0) a_done = 1'b1;   // lands while DUT is in fetch
        end
        if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) begin
                a_done = 1'b1;
                a_dcyc.push_back(cyc);
                if (a_spur_en) a_spur_cnt = 2;
            end
        end
        if (a_draw) a_cnt = 5;
    end

    // ---------------- instance B : full 20x15 map ----------------
    logic        b_start = 1'b0;
    logic [8:0]  b_map_address;
    logic [7:0]  b_map_data = 8'd0;
    logic [15:0] b_tile_address;
    logic [7:0]  b_x, b_y;
    logic        b_draw, b_done = 1'b0, b_busy, b_fd;

    tilemap_scanner #(.MAP_W(20), .MAP_H(15), .MAP_AW(9),
                      .TILE_BASE(16'h0000), .TILE_SHIFT(6)) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .map_address(b_map_address), .map_data(b_map_data),
        .tile_address(b_tile_address), .x_out(b_x), .y_out(b_y),
        .draw(b_draw), .drawer_done(b_done), .busy(b_busy), .frame_done(b_fd)
    );

    logic [7:0] b_mem [512];
    logic [8:0] b_rd_addr = 9'd0;
    int b_lx[$], b_ly[$], b_la[$];
    int b_fd_cnt = 0, b_cnt = 0;

    always @(negedge clk) begin
        if (b_draw) begin
            b_lx.push_back(int'(b_x));
            b_ly.push_back(int'(b_y));
            b_la.push_back(int'(b_tile_address));
        end
        if (b_fd) b_fd_cnt++;
        b_map_data = b_mem[b_rd_addr];
        b_rd_addr  = b_map_address;
        b_done = 1'b0;
        if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) b_done = 1'b1;
        end
        if (b_draw) b_cnt = 2;
    end

    // ---------------- stimulus helpers (no checks) ----------------
    task automatic clear_a_logs();
        a_lx.delete(); a_ly.delete(); a_la.delete(); a_lc.delete(); a_dcyc.delete();
        for (int i = 0; i < 4; i++) a_acyc[i] = -1;
        a_fd_cnt = 0;
    endtask

    // Pulses start, optionally re-pulses it mid-scan, and waits (bounded) for
    // frame_done. busy_lows counts cycles where busy dropped before frame_done.
    task automatic run_a(input bit extra, output int start_cyc, output int busy_lows);
        int n;
        busy_lows = 0;
        @(negedge clk);
        a_start   = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        a_start = 1'b0;
        n = 0;
        while (a_fd_cnt == 0 && n < 300) begin
            if (!a_busy && !a_fd) busy_lows++;
            @(negedge clk);
            n++;
            if (extra) a_start = (n == 4 || n == 9 || n == 17 || n == 30);
        end
        a_start = 1'b0;
        if (a_fd_cnt == 0) begin
            checks++; errors++;
            $display("FAIL a_scan_timeout: frame_done count %0d, required 1", a_fd_cnt);
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_busy !== 1'b0 || a_draw !== 1'b0 || a_fd !== 1'b0) begin
            errors++; $display("FAIL reset_a_ctrl: busy=%b draw=%b fd=%b, required 0 0 0", a_busy, a_draw, a_fd); end
        checks++; if (a_map_address !== 2'd0 || a_tile_address !== 16'd0) begin
            errors++; $display("FAIL reset_a_addr: map=%0h tile=%0h, required 0 0", a_map_address, a_tile_address); end
        checks++; if (a_x !== 8'd0 || a_y !== 8'd0) begin
            errors++; $display("FAIL reset_a_xy: x=%0d y=%0d, required 0 0", a_x, a_y); end
        checks++; if (b_busy !== 1'b0 || b_draw !== 1'b0 || b_fd !== 1'b0 || b_map_address !== 9'd0) begin
            errors++; $display("FAIL reset_b: busy=%b draw=%b fd=%b map=%0h, required all 0", b_busy, b_draw, b_fd, b_map_address); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int sc, lows;
        clear_a_logs();
        a_spur_en = 1'b0;
        run_a(1'b0, sc, lows);
        checks++; if (a_lx.size() != ea_x.size()) begin
            errors++; $display("FAIL basic_count: draws %0d, required %0d", a_lx.size(), ea_x.size()); end
        for (int k = 0; k < ea_x.size() && k < a_lx.size(); k++) begin
            checks++;
            if (a_lx[k] != ea_x[k] || a_ly[k] != ea_y[k] || a_la[k] != ea_a[k]) begin
                errors++; $display("FAIL basic_draw%0d: (%0d,%0d) addr %0h, required (%0d,%0d) addr %0h",
                                   k, a_lx[k], a_ly[k], a_la[k], ea_x[k], ea_y[k], ea_a[k]); end
        end
        checks++; if (a_fd_cnt != 1) begin
            errors++; $display("FAIL basic_frame_done: count %0d, required 1", a_fd_cnt); end
        checks++; if (a_busy !== 1'b0 || lows != 0) begin
            errors++; $display("FAIL basic_busy: busy=%b early_lows=%0d, required 0 0", a_busy, lows); end
        checks++; if (a_lc.size() == 0 || a_lc[0] != sc + 3) begin
            errors++; $display("FAIL start_to_draw: first draw cycle %0d, required %0d",
                               (a_lc.size() > 0) ? a_lc[0] : -1, sc + 3); end
        checks++; if (a_dcyc.size() == 0 || a_acyc[1] != a_dcyc[0] + 3) begin
            errors++; $display("FAIL done_to_addr: address change cycle %0d, required %0d",
                               a_acyc[1], (a_dcyc.size() > 0) ? a_dcyc[0] + 3 : -1); end
    endtask

    task automatic test_back_to_back();
        int sc, lows;
        clear_a_logs();
        a_spur_en = 1'b1;
        run_a(1'b1, sc, lows);
        a_spur_en = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (a_lx.size() != ea_x.size()) begin
            errors++; $display("FAIL noise_count: draws %0d, required %0d", a_lx.size(), ea_x.size()); end
        for (int k = 0; k < ea_x.size() && k < a_lx.size(); k++) begin
            checks++;
            if (a_lx[k] != ea_x[k] || a_ly[k] != ea_y[k] || a_la[k] != ea_a[k]) begin
                errors++; $display("FAIL noise_draw%0d: (%0d,%0d) addr %0h, required (%0d,%0d) addr %0h",
                                   k, a_lx[k], a_ly[k], a_la[k], ea_x[k], ea_y[k], ea_a[k]); end
        end
        checks++; if (a_fd_cnt != 1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL noise_frame: frame_done %0d busy %b, required 1 0", a_fd_cnt, a_busy); end
    endtask

    task automatic test_reset_abort();
        int n, sc, lows;
        clear_a_logs();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        n = 0;
        while (a_lx.size() < 2 && n < 100) begin @(negedge clk); n++; end
        checks++; if (a_lx.size() < 2) begin
            errors++; $display("FAIL abort_reach: draws %0d, required 2", a_lx.size()); end
        @(negedge clk);            // drawer still busy: DUT waiting for done
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_busy !== 1'b0 || a_draw !== 1'b0 || a_fd !== 1'b0) begin
            errors++; $display("FAIL abort_ctrl: busy=%b draw=%b fd=%b, required 0 0 0", a_busy, a_draw, a_fd); end
        checks++; if (a_map_address !== 2'd0 || a_tile_address !== 16'd0 || a_x !== 8'd0 || a_y !== 8'd0) begin
            errors++; $display("FAIL abort_outputs: map=%0h tile=%0h x=%0d y=%0d, required all 0",
                               a_map_address, a_tile_address, a_x, a_y); end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);  // stale done from the aborted tile arrives here
        checks++; if (a_lx.size() != 2 || a_busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: draws %0d busy %b, required 2 0", a_lx.size(), a_busy); end
        clear_a_logs();
        run_a(1'b0, sc, lows);
        checks++; if (a_lx.size() != ea_x.size()) begin
            errors++; $display("FAIL rescan_count: draws %0d, required %0d", a_lx.size(), ea_x.size()); end
        checks++; if (a_lx.size() == 0 || a_lx[0] != 0 || a_ly[0] != 0 || a_la[0] != 'h00C0) begin
            errors++; $display("FAIL rescan_first: (%0d,%0d) addr %0h, required (0,0) addr c0",
                               (a_lx.size() > 0) ? a_lx[0] : -1, (a_ly.size() > 0) ? a_ly[0] : -1,
                               (a_la.size() > 0) ? a_la[0] : -1); end
    endtask

    task automatic test_full_map();
        int n, bad, first_bad, found;
        int ex[$], ey[$], ea[$];
        for (int c = 0; c < 300; c++) begin
`ifdef TILEMAP_SKIP_EMPTY_EN
            if ((c % 256) == 0) continue;
`endif
            ex.push_back((c % 20) * 8);
            ey.push_back((c / 20) * 8);
            ea.push_back((c % 256) << 6);
        end
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        n = 0;
        while (b_fd_cnt == 0 && n < 5000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++; if (b_fd_cnt != 1 || b_busy !== 1'b0) begin
            errors++; $display("FAIL full_frame: frame_done %0d busy %b, required 1 0", b_fd_cnt, b_busy); end
        checks++; if (b_lx.size() != ex.size()) begin
            errors++; $display("FAIL full_count: draws %0d, required %0d", b_lx.size(), ex.size()); end
        bad = 0; first_bad = -1;
        for (int k = 0; k < ex.size() && k < b_lx.size(); k++)
            if (b_lx[k] != ex[k] || b_ly[k] != ey[k] || b_la[k] != ea[k]) begin
                bad++; if (first_bad < 0) first_bad = k; end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL full_sequence: %0d wrong draws, first at %0d, required 0", bad, first_bad); end
        checks++; if (b_lx.size() == 0 || b_lx[$] != 152 || b_ly[$] != 112) begin
            errors++; $display("FAIL full_last: (%0d,%0d), required (152,112)",
                               (b_lx.size() > 0) ? b_lx[$] : -1, (b_ly.size() > 0) ? b_ly[$] : -1); end
        found = 0;
        for (int k = 0; k < b_la.size(); k++)
            if (b_la[k] == 'h3FC0 && b_lx[k] == 120 && b_ly[k] == 96) found++;
        checks++; if (found != 1) begin
            errors++; $display("FAIL full_index255: draws at (120,96) addr 3fc0 = %0d, required 1", found); end
    endtask

    initial begin
        a_mem[0] = 8'd3; a_mem[1] = 8'd0; a_mem[2] = 8'd1; a_mem[3] = 8'd2;
        for (int i = 0; i < 512; i++) b_mem[i] = 8'(i);
        for (int i = 0; i < 4; i++) a_acyc[i] = -1;
        ea_x.push_back(0); ea_y.push_back(0); ea_a.push_back('h00C0);
`ifndef TILEMAP_SKIP_EMPTY_EN
        ea_x.push_back(8); ea_y.push_back(0); ea_a.push_back('h0000);
`endif
        ea_x.push_back(0); ea_y.push_back(8); ea_a.push_back('h0040);
        ea_x.push_back(8); ea_y.push_back(8); ea_a.push_back('h0080);

        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_abort();
        test_full_map();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
